// File: rtl/c1541_gcr_shifter.sv
// c1541_gcr_shifter
//   GCR read/write shift register of a 1541-style drive. In read mode it
//   assembles bit-cells from the head into bytes. It detects SYNC marks,
//   which are runs of SYNC_LEN or more ones, and aligns byte framing to the
//   first 0 bit after a mark. In write mode it serialises din onto the head.
//   Each completed byte raises an active-low byte-ready flag that is gated by soe.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous, active-high reset
//   enable   : drive electronics active; low holds the block idle
//   mode     : 1 = read, 0 = write
//   soe      : byte-ready output enable
//   hclk     : one-clk bit-cell strobe from the head block
//   hf       : bit read from the head, valid with hclk
//   ht       : bit sent to the head
//   din      : byte to write
//   dout     : last assembled read byte
//   sync_n   : active-low SYNC-detected flag
//   byte_n   : active-low byte-ready flag
//   byte_ack : one-clk pulse that returns byte_n high
module c1541_gcr_shifter #(
  parameter int SYNC_LEN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic       soe,
  input  logic       hclk,
  input  logic       hf,
  output logic       ht,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sync_n,
  output logic       byte_n,
  input  logic       byte_ack
);

  localparam logic [3:0] SYNC_TH = 4'(SYNC_LEN);

  logic [9:0] rsr;
  logic [2:0] bit_cnt;
  logic [7:0] wbuf;
  logic [3:0] ones;
  logic       mode_q;

  logic       mode_edge;
  logic       bit_ev;
  logic [3:0] ones_nx;
  logic       in_sync;
  logic       byte_done;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mode_edge = mode ^ mode_q;
    // A mode change outranks a coincident strobe, so that strobe is dropped.
    bit_ev    = enable & hclk & ~mode_edge;
    ones_nx   = 4'd0;
    if (hf) ones_nx = (ones == 4'hF) ? 4'hF : ones + 4'd1;
    in_sync   = mode & hf & (ones_nx >= SYNC_TH);
    // While a SYNC mark is running, bit_cnt is pinned at 0. No byte can
    // complete in that state.
    byte_done = bit_ev & (bit_cnt == 3'd7) & ~in_sync;
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values sampled at the edge.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (reset) begin
      rsr     <= '0;
      bit_cnt <= '0;
      ones    <= '0;
      wbuf    <= '0;
      dout    <= 8'h00;
      ht      <= 1'b0;
      sync_n  <= 1'b1;
      byte_n  <= 1'b1;
    end else begin
      // A new byte-ready condition wins over a coincident acknowledge.
      if (byte_done && soe) byte_n <= 1'b0;
      else if (byte_ack)    byte_n <= 1'b1;

      if (mode_edge) begin
        bit_cnt <= '0;
        ones    <= '0;
        wbuf    <= din;
        sync_n  <= 1'b1;
      end else if (bit_ev) begin
        if (mode) begin
          rsr    <= {rsr[8:0], hf};
          ones   <= ones_nx;
          sync_n <= ~(ones_nx >= SYNC_TH);
          if (in_sync) begin
            bit_cnt <= '0;
          end else if (!sync_n) begin
            // The 0 bit that ends SYNC is bit 0 of the first byte.
            bit_cnt <= 3'd1;
          end else begin
            if (byte_done) dout <= {rsr[6:0], hf};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          ht      <= wbuf[7];
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) wbuf <= din;
          else           wbuf <= {wbuf[6:0], 1'b0};
        end
      end

      if (!enable) begin
        bit_cnt <= '0;
        ones    <= '0;
        sync_n  <= 1'b1;
        ht      <= 1'b0;
      end else if (!mode) begin
        sync_n  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/c1541_gcr_shifter.md
C1541_GCR_SHIFTER -- requirements
Module: c1541_gcr_shifter

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 10: number of consecutive 1 bits that form a SYNC mark (valid range 2-15).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: drive motor/electronics active; low holds the block idle.
REQ-005 SHALL have port mode, input, 1 bit: GCR mode, 1 = read, 0 = write.
REQ-006 SHALL have port soe, input, 1 bit: byte-ready output enable.
REQ-007 SHALL have port hclk, input, 1 bit: one-clk bit-cell strobe from the head block.
REQ-008 SHALL have port hf, input, 1 bit: bit read from the head, valid with hclk.
REQ-009 SHALL have port ht, output, 1 bit: bit sent to the head.
REQ-010 SHALL have port din, input, 8 bits: byte to write (drive VIA port A).
REQ-011 SHALL have port dout, output, 8 bits: last assembled read byte.
REQ-012 SHALL have port sync_n, output, 1 bit: active-low SYNC-detected flag.
REQ-013 SHALL have port byte_n, output, 1 bit: active-low byte-ready flag (drives CPU SO / VIA CA1).
REQ-014 SHALL have port byte_ack, input, 1 bit: one-clk pulse that clears byte_n.

Function
REQ-015 SHALL keep a 10-bit read shift register (rsr), a 3-bit bit counter (bit_cnt), an 8-bit write buffer (wbuf) and a 4-bit ones counter (ones).
REQ-016 SHALL treat hclk as a bit event only when enable=1; all other cycles hold state except the byte_ack and mode-edge rules below.
REQ-017 Read bit event (mode=1): SHALL set rsr <= {rsr[8:0], hf}; ones <= hf ? min(ones+1, 15) : 0.
REQ-018 SHALL drive sync_n low in the cycle after the read bit event that makes ones >= SYNC_LEN, and keep it low until the next read bit event with hf=0.
REQ-019 While sync_n=0 or mode=0, ones-based SYNC SHALL be evaluated only in read mode; sync_n SHALL be forced high in write mode.
REQ-020 Read mode: during SYNC, bit_cnt SHALL be held at 0. The first 0 bit that ends SYNC SHALL count as bit 0, so bit_cnt becomes 1.
REQ-021 Read mode: on the bit event with bit_cnt=7, SHALL load dout with {rsr[6:0], hf}, wrap bit_cnt to 0, and set the byte-ready condition.
REQ-022 Write bit event (mode=0): SHALL output ht <= wbuf[7] and shift wbuf left by one bit.
REQ-023 Write mode: on the bit event with bit_cnt=7, SHALL load wbuf with din instead of shifting, wrap bit_cnt to 0, and set the byte-ready condition.
REQ-024 On a mode edge (either direction), detected by a registered copy of mode: SHALL set bit_cnt = 0 and ones = 0, and load wbuf with din; this takes priority over a coincident hclk.
REQ-025 Byte-ready condition SHALL drive byte_n low the next clk only if soe=1; if soe=0 the condition is discarded.
REQ-026 byte_ack SHALL return byte_n high. If byte_ack and a new byte-ready condition occur in the same clk, byte_n SHALL stay low.
REQ-027 enable=0 SHALL set bit_cnt = 0, ones = 0, sync_n = 1 and ht = 0. dout, wbuf and byte_n SHALL hold.
REQ-028 All counters SHALL wrap or saturate exactly as stated, with no overflow into adjacent bits; bit_cnt SHALL wrap modulo 8.

Reset
REQ-029 reset SHALL set: rsr = 0, bit_cnt = 0, ones = 0, wbuf = 0, dout = 8'h00, ht = 0, sync_n = 1, byte_n = 1, registered mode = mode.
REQ-030 reset SHALL take priority over every other input, including mid-byte and mid-SYNC.

Verification
REQ-031 Read, soe=1: feed 12 ones then bits 01010010 -> sync_n low after the 10th one, high after the first 0; after the 8th data bit, dout = 8'h52 and byte_n low.
REQ-032 Write: din = 8'hA5, toggle mode 1 -> 0, give 8 hclk -> ht sequence 1,0,1,0,0,1,0,1; byte_n low after the 8th strobe; wbuf reloaded from din.
REQ-033 byte_ack coincident with a byte-complete strobe -> byte_n stays low. byte_ack alone -> byte_n high the next clk.
REQ-034 soe=0 through a full read byte -> dout updates and byte_n stays high.
REQ-035 Assert reset after 4 read bits -> all outputs at reset values; the next 8 bits after a SYNC yield a correctly aligned dout.
REQ-036 enable=0 for 3 hclk strobes mid-byte -> no shift, bit_cnt = 0, sync_n = 1; bytes frame correctly after enable returns.
